// File: rtl/data_mem_bx.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_bx
// Purpose  : Single-port byte-addressable data memory with byte/half/word
//            access, optional sign extension on sub-word loads, a fixed
//            number of wait states per access, and an access-fault flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH       - number of 32-bit words (>= 2)
//   WAIT_CYCLES - extra wait states per access (0..15)
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset
//   req      in   1   access request (accepted only while idle)
//   we       in   1   1 = store, 0 = load
//   size     in   2   00 byte, 01 half, 10 word, 11 reserved
//   sign_ext in   1   sign-extend sub-word loads
//   addr     in   BA  byte address, BA = clog2(DEPTH)+2
//   wdata    in   32  store data, right-aligned
//   rdata    out  32  registered load result
//   ready    out  1   one-cycle completion pulse
//   err      out  1   access fault, valid while ready=1
//   busy     out  1   access in progress
// Configuration macro
//   DMEM_MISALIGN_EN - when defined, misaligned half/word accesses fault;
//                      otherwise the low address bits are ignored.
// ============================================================================
module data_mem_bx #(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      we,
    input  logic [1:0]                size,
    input  logic                      sign_ext,
    input  logic [$clog2(DEPTH)+1:0]  addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic                      ready,
    output logic                      err,
    output logic                      busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int BA = AW + 2;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;

    // Request fields captured on acceptance; inputs are ignored afterwards.
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_sext;
    logic [BA-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_cnt;

    logic [31:0]   r_rdata;
    logic          r_err;

    // Contents start at zero and are deliberately outside the reset domain.
    logic [31:0]   r_mem [DEPTH] = '{default: '0};

    logic          w_commit;
    logic [AW-1:0] w_word_idx;
    logic          w_in_range;
    logic          w_misalign;
    logic          w_err;
    logic [31:0]   w_cur_word;
    logic [31:0]   w_store_word;
    logic [31:0]   w_load_word;
    logic [7:0]    w_lane_byte;
    logic [15:0]   w_lane_half;

    assign w_commit   = (r_state == c_WAIT) && (r_cnt == 4'd0);
    assign w_word_idx = r_addr[BA-1:2];

    // A power-of-two depth covers every index the address can express.
    generate
        if (DEPTH == (1 << AW)) begin : g_range_full
            assign w_in_range = 1'b1;
        end else begin : g_range_partial
            assign w_in_range = ({1'b0, w_word_idx} < (AW+1)'(DEPTH));
        end
    endgenerate

`ifdef DMEM_MISALIGN_EN
    assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                        ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err      = !w_in_range || (r_size == 2'b11) || w_misalign;
    assign w_cur_word = w_in_range ? r_mem[w_word_idx] : 32'd0;

    // Lane extraction; half accesses use addr[1] only, so addr[0] is
    // ignored unless the misalignment check above already faulted.
    assign w_lane_byte = w_cur_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_lane_half = w_cur_word[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_store_word = w_cur_word;
        case (r_size)
            2'b00:   w_store_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01:   w_store_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_store_word = r_wdata;
        endcase
    end

    always_comb begin
        w_load_word = w_cur_word;
        case (r_size)
            2'b00:   w_load_word = {{24{r_sext & w_lane_byte[7]}}, w_lane_byte};
            2'b01:   w_load_word = {{16{r_sext & w_lane_half[15]}}, w_lane_half};
            default: w_load_word = w_cur_word;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (req) w_next_state = c_WAIT;
            c_WAIT:  if (r_cnt == 4'd0) w_next_state = c_RESP;
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && req) begin
                r_we    <= we;
                r_size  <= size;
                r_sext  <= sign_ext;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_cnt   <= c_WAIT_LOAD;
            end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Stores and faulting accesses return zero read data.
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_we) ? 32'd0 : w_load_word;
            end
        end
    end

    // A reset on the commit edge wins, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_we && !w_err) begin
            r_mem[w_word_idx] <= w_store_word;
        end
    end

    assign rdata = r_rdata;
    assign err   = r_err;
    assign ready = (r_state == c_RESP);
    assign busy  = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bx.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_bx
// Purpose  : Randomized self-checking bench for data_mem_bx. A byte-array
//            reference model produces the expected response of each access;
//            a monitor pops and compares whenever ready pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_bx;

    localparam int DEPTH       = 24;
    localparam int WAIT_CYCLES = 3;
    localparam int BA          = $clog2(DEPTH) + 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          req      = 1'b0;
    logic          we       = 1'b0;
    logic [1:0]    size     = 2'b00;
    logic          sign_ext = 1'b0;
    logic [BA-1:0] addr     = '0;
    logic [31:0]   wdata    = 32'd0;
    logic [31:0]   rdata;
    logic          ready;
    logic          err;
    logic          busy;

    data_mem_bx #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    byte unsigned model_mem [DEPTH*4];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int issue_cyc = -100;
    int due_cyc   = -100;
    logic rst_q   = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sx,
                                   input int a, input logic [31:0] wd);
        exp_t e;
        int n;
        int base;
        logic [31:0] v;
        e.rdata  = 32'd0;
        e.err    = 1'b0;
        e.chk_rd = !w;
        e.due    = 0;
        n = 1 << sz;
        if (sz == 2'b11 || (a / 4) >= DEPTH) e.err = 1'b1;
`ifdef DMEM_MISALIGN_EN
        if (sz != 2'b11 && (a % n) != 0) e.err = 1'b1;
`endif
        if (e.err) begin
            e.chk_rd = 1'b1;
            return e;
        end
        base = a - (a % n);
        if (w) begin
            for (int i = 0; i < n; i++) model_mem[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(model_mem[base + i]) << (8 * i));
            if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic scramble();
        req      = 1'($urandom);
        we       = 1'($urandom);
        size     = 2'($urandom);
        sign_ext = 1'($urandom);
        addr     = BA'($urandom);
        wdata    = $urandom;
    endtask

    // Issue one access from a negedge in IDLE; returns at a negedge in IDLE.
    // Inputs are scrambled while busy, since the DUT must ignore them.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [BA-1:0] a, input logic [31:0] wd, input bit abort);
        exp_t e;
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        issue_cyc = cyc;
        due_cyc   = cyc + 2 + WAIT_CYCLES;
        if (!abort) begin
            e     = model(w, sz, sx, int'(a), wd);
            e.due = cyc + 2 + WAIT_CYCLES;
            sbq.push_back(e);
            repeat (WAIT_CYCLES + 2) begin
                @(negedge clk);
                scramble();
            end
            @(negedge clk);
            req = 1'b0;
        end else begin
            @(negedge clk);
            scramble();
            rst     = 1'b1;
            due_cyc = cyc;
            @(negedge clk);
            rst = 1'b0;
            req = 1'b0;
            @(negedge clk);
        end
    endtask

    // Monitor: samples one time unit after each rising edge.
    logic [31:0] hold_rd       = 32'd0;
    logic        hold_err      = 1'b0;
    logic        hold_rd_valid = 1'b1;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_q) begin
            chk("reset_rdata", rdata, 32'd0);
            chk("reset_err",   {31'd0, err},   32'd0);
            chk("reset_ready", {31'd0, ready}, 32'd0);
            hold_rd       = 32'd0;
            hold_err      = 1'b0;
            hold_rd_valid = 1'b1;
        end else if (ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ready", {31'd0, ready}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("ready_cycle", 32'(cyc), 32'(e.due));
                chk("err", {31'd0, err}, {31'd0, e.err});
                if (e.chk_rd) chk("rdata", rdata, e.rdata);
                hold_err      = e.err;
                hold_rd       = e.rdata;
                hold_rd_valid = e.chk_rd;
            end
        end else begin
            if (sbq.size() != 0 && cyc >= sbq[0].due) begin
                e = sbq.pop_front();
                chk("missing_ready", {31'd0, ready}, 32'd1);
            end
            chk("hold_err", {31'd0, err}, {31'd0, hold_err});
            if (hold_rd_valid) chk("hold_rdata", rdata, hold_rd);
        end
        chk("busy", {31'd0, busy}, {31'd0, (cyc > issue_cyc) && (cyc <= due_cyc)});
    end

    initial begin
        logic [BA-1:0] ra;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Word store / load round trip
        access(1'b1, 2'b10, 1'b0, BA'('h10), 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 2'b10, 1'b0, BA'('h10), 32'd0, 1'b0);
        // Byte lane store and sign/zero-extended loads
        access(1'b1, 2'b00, 1'b0, BA'('h13), 32'h0000_0080, 1'b0);
        access(1'b0, 2'b00, 1'b1, BA'('h13), 32'd0, 1'b0);
        access(1'b0, 2'b00, 1'b0, BA'('h13), 32'd0, 1'b0);
        access(1'b0, 2'b10, 1'b1, BA'('h10), 32'd0, 1'b0);
        // Out-of-range word index, last valid word
        access(1'b1, 2'b10, 1'b0, BA'('h60), 32'h55AA_55AA, 1'b0);
        access(1'b0, 2'b10, 1'b0, BA'('h5C), 32'd0, 1'b0);
        access(1'b0, 2'b10, 1'b0, BA'('h60), 32'd0, 1'b0);
        // Misaligned half store, then inspect the word
        access(1'b1, 2'b01, 1'b0, BA'('h11), 32'h1234_BEEF, 1'b0);
        access(1'b0, 2'b10, 1'b0, BA'('h10), 32'd0, 1'b0);
        access(1'b0, 2'b01, 1'b1, BA'('h12), 32'd0, 1'b0);
        // Reserved size
        access(1'b1, 2'b11, 1'b0, BA'('h14), 32'hFFFF_FFFF, 1'b0);
        access(1'b0, 2'b10, 1'b0, BA'('h14), 32'd0, 1'b0);
        access(1'b0, 2'b11, 1'b0, BA'('h10), 32'd0, 1'b0);
        // Reset during WAIT aborts the store
        access(1'b1, 2'b10, 1'b0, BA'('h20), 32'h1234_5678, 1'b1);
        access(1'b0, 2'b10, 1'b0, BA'('h20), 32'd0, 1'b0);

        // Randomized traffic, biased toward low addresses for reuse
        for (int i = 0; i < 200; i++) begin
            ra = ($urandom_range(0, 1) == 0) ? BA'($urandom_range(0, 31))
                                             : BA'($urandom_range(0, (1 << BA) - 1));
            access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom, 1'b0);
        end

        repeat (WAIT_CYCLES + 6) @(negedge clk);
        if (sbq.size() != 0) begin
            $display("FAIL drain: %0d responses outstanding, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_bx.md
DATA_MEM_BX -- requirements
Module: data_mem_bx

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 32-bit words (any value >= 2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, meaning extra wait states per access (0..15).
REQ-003 SHALL derive local AW = clog2(DEPTH) and byte-address width BA = AW+2.
REQ-004 SHALL have ports, in this order:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, reset: synchronous, active-high.
- req, input, 1, access request.
- we, input, 1, 1 = store, 0 = load.
- size, input, 2, 00 byte, 01 half, 10 word, 11 reserved.
- sign_ext, input, 1, sign-extend sub-word loads.
- addr, input, BA, byte address.
- wdata, input, 32, store data, right-aligned.
- rdata, output, 32, registered load result.
- ready, output, 1, one-cycle completion pulse.
- err, output, 1, access fault, valid while ready=1.
- busy, output, 1, access in progress.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, RESP; busy=1 in WAIT and RESP.
REQ-006 In IDLE with req=1, SHALL latch we/size/sign_ext/addr/wdata, load wait counter with WAIT_CYCLES, and go to WAIT.
REQ-007 In IDLE with req=0, SHALL stay in IDLE; input changes outside IDLE are ignored.
REQ-008 In WAIT with counter != 0, SHALL decrement the counter and stay in WAIT.
REQ-009 In WAIT with counter == 0, SHALL perform the access (commit store or register load result), set err, and go to RESP.
REQ-010 In RESP, ready SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE; req seen in RESP is not accepted.
REQ-011 Latency: req high in cycle 0 SHALL give ready in cycle 2+WAIT_CYCLES; back-to-back throughput is one access per 3+WAIT_CYCLES cycles.
REQ-012 Lanes are little-endian: byte k = bits 8k+7:8k of word addr[BA-1:2]; half at addr[1] = bits 16*addr[1]+15:16*addr[1].
REQ-013 Stores SHALL write only the selected lanes from wdata low bits; other bytes are unchanged.
REQ-014 Loads SHALL right-align the lane into rdata, zero-extending when sign_ext=0 and sign-extending when sign_ext=1; word loads ignore sign_ext.
REQ-015 Word index >= DEPTH or size=11 SHALL set err=1, suppress the store, and return rdata=0.
REQ-016 rdata and err SHALL hold their values from RESP until the next commit.
REQ-017 Memory contents SHALL be zero at time 0 and SHALL be unaffected by rst.

Reset
REQ-018 rst=1 at a clock edge SHALL force IDLE, counter=0, ready=0, err=0, rdata=0, busy=0.
REQ-019 rst during WAIT before the commit edge SHALL abort the access with no memory write and no ready pulse.
REQ-020 rst SHALL take priority over req on the same edge.

Configuration
REQ-021 Macro DMEM_MISALIGN_EN defined: half with addr[0]=1, or word with addr[1:0]!=0, SHALL set err=1, suppress the store, and return rdata=0.
REQ-022 Macro DMEM_MISALIGN_EN undefined: half SHALL ignore addr[0], word SHALL ignore addr[1:0], and misalignment SHALL never set err.

Verification
REQ-023 WAIT_CYCLES=0: store word 0xDEADBEEF at addr 0x10 (req cycle 0) -> ready cycle 2, err=0; load word at 0x10 -> rdata=0xDEADBEEF.
REQ-024 Store byte 0x80 at 0x13, then load byte at 0x13 with sign_ext=1 -> 0xFFFFFF80; with sign_ext=0 -> 0x00000080; load word at 0x10 -> 0x80ADBEEF.
REQ-025 WAIT_CYCLES=3: load request in cycle 0 -> ready exactly in cycle 5, busy high in cycles 1-5.
REQ-026 DEPTH=24: word store to addr 0x60 -> err=1, no memory change; with DMEM_MISALIGN_EN, half store at 0x11 -> err=1, word unchanged.
REQ-027 Assert rst during WAIT of a store (WAIT_CYCLES=2) -> no ready pulse, target word keeps its old value, outputs return to zero.
